// File: rtl/memory_responder_pkg.sv
// Shared types for the core/memory request interface and the responder FSM.
package memory_responder_pkg;

    localparam int NUM_OF_CORES = 4;
    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;

    // One request (or response) beat on the interconnect.
    typedef struct packed {
        logic                  vld;
        logic [3:0]            core_id;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } request_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_rsp_state_t;

endpackage

// File: rtl/memory_responder_fifo.sv
// Small synchronous FIFO with first-word fall-through head and a level count.
// A push while full is legal when a pop happens on the same edge; the caller
// is responsible for never pushing into a full FIFO without a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // Entry storage; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign empty = (r_level == '0);
    assign full  = (r_level == LVL_W'(DEPTH));
    assign level = r_level;

endmodule

// File: rtl/memory_responder.sv
// Memory-side endpoint: queues incoming requests, services them in order
// against a local word-addressed RAM with a fixed access time, and returns a
// registered response carrying the requester's core_id.
// Optional macro MEM_WRITE_ACK_EN: when defined, writes also return an ack
// response; otherwise writes are posted and only reads respond.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int ACCESS_CYCLES = 2,
    parameter int MEM_WORDS     = 256
) (
    input  logic                              clk,
    input  logic                              reset,
    input  request_t                          mem_req,
    output request_t                          mem_rsp,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow_err
);
    localparam int REQ_W    = $bits(request_t);
    localparam int LVL_W    = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W    = $clog2(MEM_WORDS);
    localparam int CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

`ifdef MEM_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    mem_rsp_state_t r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    request_t         r_cur, w_cur_next;
    request_t         w_head;
    logic [REQ_W-1:0] w_head_bits;
    logic             w_full, w_empty, w_push, w_pop, w_drop, w_done, w_rsp_fire;
    logic [IDX_W-1:0] w_idx;
    logic [LVL_W-1:0] w_level_next;

    logic [DATA_WIDTH-1:0] r_ram [MEM_WORDS];
    logic [DATA_WIDTH-1:0] r_ram_rdata;

    logic                  r_rsp_vld, r_rsp_we, r_rsp_rd, r_busy, r_overflow;
    logic [3:0]            r_rsp_core;
    logic [ADDR_WIDTH-1:0] r_rsp_addr;
    logic [DATA_WIDTH-1:0] r_rsp_wdata;

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (mem_req),
        .dout  (w_head_bits),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    assign w_head = request_t'(w_head_bits);
    assign w_idx  = r_cur.addr[IDX_W-1:0];

    // No backpressure: a full FIFO still takes a request if it drains this edge.
    assign w_push = mem_req.vld && (!w_full || w_pop);
    assign w_drop = mem_req.vld && w_full && !w_pop;
    assign w_rsp_fire   = w_done && r_cur.vld && (!r_cur.we || WRITE_ACK);
    assign w_level_next = fifo_level + LVL_W'(w_push) - LVL_W'(w_pop);

    // Next-state logic: pop a new request on entry and after each final access cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cur_next   = r_cur;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_cur_next   = w_head;
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_done = 1'b1;
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_cur_next = w_head;
                        w_cnt_next = CNT_LOAD;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM, access counter and current-request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cur   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cur   <= w_cur_next;
        end
    end

    // RAM port: write or read on the final access edge; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (w_done && !reset) begin
            if (r_cur.we) begin
                r_ram[w_idx] <= r_cur.data;
            end else begin
                r_ram_rdata <= r_ram[w_idx];
            end
        end
    end

    // Response fields: vld pulses per completion, other fields hold until the next response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_vld   <= 1'b0;
            r_rsp_core  <= '0;
            r_rsp_we    <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_wdata <= '0;
            r_rsp_rd    <= 1'b0;
        end else begin
            r_rsp_vld <= w_rsp_fire;
            if (w_rsp_fire) begin
                r_rsp_core  <= r_cur.core_id;
                r_rsp_we    <= r_cur.we;
                r_rsp_addr  <= r_cur.addr;
                r_rsp_wdata <= r_cur.data;
                r_rsp_rd    <= !r_cur.we;
            end
        end
    end

    // Status flags reflecting the post-edge state; overflow is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_busy     <= (w_state_next == ACCESS) || (w_level_next != '0);
            r_overflow <= r_overflow || w_drop;
        end
    end

    // Assemble the response; read data comes straight from the RAM output register.
    always_comb begin
        mem_rsp         = '0;
        mem_rsp.vld     = r_rsp_vld;
        mem_rsp.core_id = r_rsp_core;
        mem_rsp.we      = r_rsp_we;
        mem_rsp.addr    = r_rsp_addr;
        mem_rsp.data    = r_rsp_rd ? r_ram_rdata : r_rsp_wdata;
    end

    assign busy         = r_busy;
    assign overflow_err = r_overflow;

endmodule

// File: tb/tb_memory_responder.sv
// Randomized scoreboard bench for memory_responder. The reference model is a
// queueing model: each accepted request starts service at
// max(arrival+2, previous completion) and finishes ACCESS_CYCLES later.
`timescale 1ns/1ps
module tb_memory_responder;
    import memory_responder_pkg::*;

    localparam int FIFO_DEPTH    = 4;
    localparam int ACCESS_CYCLES = 2;
    localparam int MEM_WORDS     = 256;
    localparam int A             = ACCESS_CYCLES;
    localparam int IDX_W         = $clog2(MEM_WORDS);
    localparam int INF           = 32'h3fff_ffff;
`ifdef MEM_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic     clk = 1'b0;
    logic     reset = 1'b1;
    request_t mem_req = '0;
    request_t mem_rsp;
    logic     busy;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level;
    logic     overflow_err;

    memory_responder #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .ACCESS_CYCLES (ACCESS_CYCLES),
        .MEM_WORDS     (MEM_WORDS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_rsp      (mem_rsp),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        request_t rsp;
    } exp_t;

    exp_t exp_q[$];
    int   acc_t[$];
    int   acc_s[$];
    int   acc_kill[$];
    int   last_r    = 0;
    int   ovf_from  = INF;
    int   ovf_until = INF;
    int   zchk      = -1;
    logic [31:0] mram [MEM_WORDS];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Number of accepted requests waiting in the FIFO during cycle x.
    function automatic int model_level(input int x);
        int n = 0;
        foreach (acc_t[j])
            if (x <= acc_kill[j] && acc_t[j] + 1 <= x && x <= acc_s[j] - 1) n++;
        return n;
    endfunction

    // True if some request is queued or being serviced during cycle x.
    function automatic bit model_busy(input int x);
        foreach (acc_t[j])
            if (x <= acc_kill[j] && acc_t[j] + 1 <= x && x <= acc_s[j] + A - 1) return 1'b1;
        return 1'b0;
    endfunction

    // True if a request leaves the FIFO on the edge that ends cycle x.
    function automatic bit model_pop_at(input int x);
        foreach (acc_s[j])
            if (x <= acc_kill[j] && acc_s[j] - 1 == x) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_ovf(input int x);
        return (x >= ovf_from) && (x < ovf_until);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus and predict its outcome.
    task automatic step(input bit v, input logic [3:0] core, input bit we,
                        input logic [31:0] addr, input logic [31:0] data, input bit no_commit);
        int t;
        int s;
        request_t r;
        exp_t e;
        logic [IDX_W-1:0] idx;
        next_cycle();
        t = cyc;
        while (acc_t.size() > 0 &&
               (((acc_s[0] + A < acc_kill[0]) ? acc_s[0] + A : acc_kill[0]) + 2 < t)) begin
            void'(acc_t.pop_front());
            void'(acc_s.pop_front());
            void'(acc_kill.pop_front());
        end
        r = '0;
        if (v) begin
            r.vld = 1'b1; r.core_id = core; r.we = we; r.addr = addr; r.data = data;
        end
        mem_req = r;
        if (!v) return;
        if (model_level(t) >= FIFO_DEPTH && !model_pop_at(t)) begin
            $display("cycle %0d drop core=%0d we=%0d addr=%h", t, core, we, addr);
            if (ovf_from == INF || ovf_until != INF) begin
                ovf_from  = t + 1;
                ovf_until = INF;
            end
            return;
        end
        s = (t + 2 > last_r) ? t + 2 : last_r;
        last_r = s + A;
        acc_t.push_back(t);
        acc_s.push_back(s);
        acc_kill.push_back(INF);
        idx = addr[IDX_W-1:0];
        e.cyc = s + A;
        e.rsp = r;
        if (!we) begin
            e.rsp.data = mram[idx];
            exp_q.push_back(e);
        end else begin
            if (!no_commit) mram[idx] = data;
            if (ACK) exp_q.push_back(e);
        end
    endtask

    task automatic idle_cycle();
        step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // One-cycle synchronous reset; everything in flight is abandoned.
    task automatic pulse_reset();
        int c;
        next_cycle();
        c = cyc;
        reset = 1'b1;
        mem_req = '0;
        foreach (acc_kill[j]) if (acc_kill[j] > c) acc_kill[j] = c;
        last_r = 0;
        while (exp_q.size() > 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
        if (ovf_from <= c) ovf_until = c + 1;
        else ovf_from = INF;
        zchk = c + 1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((model_busy(cyc) || exp_q.size() > 0 || cyc <= last_r) && n < 100) begin
            idle_cycle();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout at cycle %0d queue=%0d", cyc, exp_q.size());
        end
    endtask

    // Monitor: pops the scoreboard whenever a response appears and checks status each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_rsp cycle %0d: no response, required %h at cycle %0d",
                         cyc, exp_q[0].rsp, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (mem_rsp.vld === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp cycle %0d: got %h, required none", cyc, mem_rsp);
                end else if (exp_q[0].cyc != cyc || mem_rsp !== exp_q[0].rsp) begin
                    errors++;
                    $display("FAIL rsp cycle %0d: got %h, required %h at cycle %0d",
                             cyc, mem_rsp, exp_q[0].rsp, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end else begin
                    $display("cycle %0d rsp core=%0d we=%0d addr=%h data=%h ok",
                             cyc, mem_rsp.core_id, mem_rsp.we, mem_rsp.addr, mem_rsp.data);
                    void'(exp_q.pop_front());
                end
            end else if (mem_rsp.vld !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL rsp_vld cycle %0d: got %b, required 0/1", cyc, mem_rsp.vld);
            end
            checks++;
            if (fifo_level !== model_level(cyc)) begin
                errors++;
                $display("FAIL fifo_level cycle %0d: got %0d, required %0d", cyc, fifo_level, model_level(cyc));
            end
            checks++;
            if (busy !== model_busy(cyc)) begin
                errors++;
                $display("FAIL busy cycle %0d: got %b, required %b", cyc, busy, model_busy(cyc));
            end
            checks++;
            if (overflow_err !== exp_ovf(cyc)) begin
                errors++;
                $display("FAIL overflow_err cycle %0d: got %b, required %b", cyc, overflow_err, exp_ovf(cyc));
            end
            if (cyc == zchk) begin
                checks++;
                if (mem_rsp !== '0) begin
                    errors++;
                    $display("FAIL rsp_after_reset cycle %0d: got %h, required 0", cyc, mem_rsp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        zchk = cyc + 1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Preload the words used later, including an aliased upper address.
        for (int i = 0; i < 16; i++) begin
            a = (i == 5) ? 32'h0001_0005 : i;
            step(1'b1, 4'(i % NUM_OF_CORES), 1'b1, a, $urandom(), 1'b0);
            idle_cycle();
            idle_cycle();
        end
        step(1'b1, 4'd0, 1'b1, 32'h20, 32'h0BAD_F00D, 1'b0);
        wait_idle();

        // Write then read the same word from two different cores.
        step(1'b1, 4'd2, 1'b1, 32'h10, 32'hA5A5_0001, 1'b0);
        step(1'b1, 4'd1, 1'b0, 32'h10, 32'h0, 1'b0);
        wait_idle();

        // Reads from four cores on consecutive cycles.
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 1'b0, 32'(i), 32'h0, 1'b0);
        wait_idle();

        // Upper address bits are ignored.
        step(1'b1, 4'd3, 1'b0, 32'h0000_0005, 32'h0, 1'b0);
        step(1'b1, 4'd0, 1'b1, 32'h0001_0005, 32'h1234_5678, 1'b0);
        step(1'b1, 4'd1, 1'b0, 32'hFF00_0005, 32'h0, 1'b0);
        wait_idle();

        // Back-to-back burst long enough to overflow the FIFO.
        for (int i = 0; i < 10; i++)
            step(1'b1, 4'($urandom_range(0, NUM_OF_CORES-1)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 15)), $urandom(), 1'b0);
        wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 99) < 45, 4'($urandom_range(0, NUM_OF_CORES-1)),
                 1'($urandom_range(0, 1)),
                 ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 15)), $urandom(), 1'b0);
        wait_idle();

        // Reset on the final access edge of a write: no response, RAM untouched.
        step(1'b1, 4'd2, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b1);
        idle_cycle();
        idle_cycle();
        pulse_reset();
        step(1'b1, 4'd3, 1'b0, 32'h20, 32'h0, 1'b0);
        wait_idle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
